// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded control bundle and ID operands every cycle. When the
// instruction in EX is a load whose destination feeds the ID instruction,
// it freezes PC and IF/ID and inserts a bubble into EX. A branch flush
// squashes the ID instruction and takes priority over the hazard.
// A saturating counter records how many load-use bubbles were inserted.
module id_ex_hazard_reg #(
    parameter int data_width     = 32,
    parameter int reg_addr_width = 5,
    parameter int cnt_width      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_reg_dst,
    input  logic                      id_alu_src,
    input  logic                      id_mem_to_reg,
    input  logic                      id_reg_w,
    input  logic                      id_mem_r,
    input  logic                      id_mem_w,
    input  logic                      id_branch,
    input  logic [2:0]                id_alu_op,
    input  logic [data_width-1:0]     id_pc_plus4,
    input  logic [data_width-1:0]     id_rs_data,
    input  logic [data_width-1:0]     id_rt_data,
    input  logic [data_width-1:0]     id_imm_ext,
    input  logic [reg_addr_width-1:0] id_rs,
    input  logic [reg_addr_width-1:0] id_rt,
    input  logic [reg_addr_width-1:0] id_rd,
    input  logic [5:0]                id_funct,
    input  logic                      flush,
    output logic                      ex_reg_dst,
    output logic                      ex_alu_src,
    output logic                      ex_mem_to_reg,
    output logic                      ex_reg_w,
    output logic                      ex_mem_r,
    output logic                      ex_mem_w,
    output logic                      ex_branch,
    output logic [2:0]                ex_alu_op,
    output logic [data_width-1:0]     ex_pc_plus4,
    output logic [data_width-1:0]     ex_rs_data,
    output logic [data_width-1:0]     ex_rt_data,
    output logic [data_width-1:0]     ex_imm_ext,
    output logic [reg_addr_width-1:0] ex_rs,
    output logic [reg_addr_width-1:0] ex_rt,
    output logic [reg_addr_width-1:0] ex_rd,
    output logic [5:0]                ex_funct,
    output logic                      ex_valid,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic [cnt_width-1:0]      stall_cnt
);

    logic id_uses_rt;
    logic hazard;
    logic stall;

    // The ID instruction reads rt as a source for R-type ops, stores and branches.
    always_comb begin
        id_uses_rt = id_reg_dst | id_mem_w | id_branch;
        hazard     = ex_mem_r & ex_valid & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        stall       = hazard & ~flush;
        pc_write    = ~stall;
        if_id_write = ~stall;
    end

    // Pipeline register: flush and bubble both zero the controls; data always follows ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg_dst    <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_w      <= 1'b0;
            ex_mem_r      <= 1'b0;
            ex_mem_w      <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= 3'b000;
            ex_pc_plus4   <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm_ext    <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_funct      <= 6'd0;
            ex_valid      <= 1'b0;
        end else begin
            ex_pc_plus4 <= id_pc_plus4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm_ext  <= id_imm_ext;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            if (flush || hazard) begin
                ex_reg_dst    <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_reg_w      <= 1'b0;
                ex_mem_r      <= 1'b0;
                ex_mem_w      <= 1'b0;
                ex_branch     <= 1'b0;
                ex_alu_op     <= 3'b000;
                ex_valid      <= 1'b0;
            end else begin
                ex_reg_dst    <= id_reg_dst;
                ex_alu_src    <= id_alu_src;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_reg_w      <= id_reg_w;
                ex_mem_r      <= id_mem_r;
                ex_mem_w      <= id_mem_w;
                ex_branch     <= id_branch;
                ex_alu_op     <= id_alu_op;
                ex_valid      <= 1'b1;
            end
        end
    end

    // Count inserted load-use bubbles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, latency, load-use on rs/rt,
// $0 loads, flush priority, counter saturation and asynchronous reset mid-stall.
module tb_id_ex_hazard_reg;

    localparam int dw = 32;
    localparam int aw = 5;
    localparam int cw = 4;

    logic          clk;
    logic          rst_n;
    logic          id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_w;
    logic          id_mem_r, id_mem_w, id_branch;
    logic [2:0]    id_alu_op;
    logic [dw-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
    logic [aw-1:0] id_rs, id_rt, id_rd;
    logic [5:0]    id_funct;
    logic          flush;
    logic          ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_w;
    logic          ex_mem_r, ex_mem_w, ex_branch;
    logic [2:0]    ex_alu_op;
    logic [dw-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [aw-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;
    logic          ex_valid, pc_write, if_id_write;
    logic [cw-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_hazard_reg #(.data_width(dw), .reg_addr_width(aw), .cnt_width(cw)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_w(id_reg_w), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_branch(id_branch),
        .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        id_reg_dst = 0; id_alu_src = 0; id_mem_to_reg = 0; id_reg_w = 0;
        id_mem_r = 0; id_mem_w = 0; id_branch = 0; id_alu_op = 3'b000;
        id_pc_plus4 = 32'h0000_1004; id_rs_data = 32'h1111_0000;
        id_rt_data = 32'h2222_0000; id_imm_ext = 32'h0000_0010;
        id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 6'd0; flush = 0;
    endtask

    // lw rt, 0(rs=1)
    task automatic drive_lw(input logic [aw-1:0] rt);
        drive_nop();
        id_mem_r = 1; id_reg_w = 1; id_mem_to_reg = 1; id_alu_src = 1;
        id_rs = 5'd1; id_rt = rt;
    endtask

    // add rd=3, rs, rt=2 (R-type, uses rt)
    task automatic drive_add(input logic [aw-1:0] rs);
        drive_nop();
        id_reg_dst = 1; id_reg_w = 1; id_alu_op = 3'b010;
        id_rs = rs; id_rt = 5'd2; id_rd = 5'd3; id_funct = 6'h20;
    endtask

    initial begin
        drive_nop();
        rst_n = 0;
        id_mem_r    = 1'($urandom);
        id_reg_w    = 1'($urandom);
        id_alu_op   = 3'($urandom);
        id_rs_data  = $urandom;
        id_pc_plus4 = $urandom;
        id_rt       = 5'($urandom);
        id_rs       = id_rt;
        tick();
        tick();
        check("rst_ex_reg_w", 64'(ex_reg_w), 0);
        check("rst_ex_mem_r", 64'(ex_mem_r), 0);
        check("rst_ex_alu_op", 64'(ex_alu_op), 0);
        check("rst_ex_rs_data", 64'(ex_rs_data), 0);
        check("rst_ex_valid", 64'(ex_valid), 0);
        check("rst_stall_cnt", 64'(stall_cnt), 0);
        check("rst_pc_write", 64'(pc_write), 1);
        check("rst_if_id_write", 64'(if_id_write), 1);

        // Release and check single-cycle latency.
        rst_n = 1;
        drive_nop();
        id_reg_w = 1; id_alu_op = 3'b010; id_rd = 5'd8; id_rs_data = 32'hCAFE_0001;
        tick();
        check("lat_ex_reg_w", 64'(ex_reg_w), 1);
        check("lat_ex_alu_op", 64'(ex_alu_op), 64'h2);
        check("lat_ex_rd", 64'(ex_rd), 8);
        check("lat_ex_rs_data", 64'(ex_rs_data), 64'hCAFE_0001);
        check("lat_ex_valid", 64'(ex_valid), 1);

        // Load-use on rs.
        drive_lw(5'd9);
        tick();
        drive_add(5'd9);
        #1;
        check("rs_pc_write_stall", 64'(pc_write), 0);
        check("rs_if_id_write_stall", 64'(if_id_write), 0);
        tick();
        check("rs_bubble_reg_w", 64'(ex_reg_w), 0);
        check("rs_bubble_valid", 64'(ex_valid), 0);
        check("rs_bubble_ex_rs", 64'(ex_rs), 9);
        check("rs_stall_cnt", 64'(stall_cnt), 1);
        check("rs_pc_write_resume", 64'(pc_write), 1);
        tick();
        check("rs_add_valid", 64'(ex_valid), 1);
        check("rs_add_reg_w", 64'(ex_reg_w), 1);
        check("rs_add_rd", 64'(ex_rd), 3);

        // rt not used by addi: no stall.
        drive_lw(5'd10);
        tick();
        drive_nop();
        id_reg_w = 1; id_alu_src = 1; id_rs = 5'd4; id_rt = 5'd10;
        #1;
        check("addi_pc_write", 64'(pc_write), 1);
        tick();
        check("addi_valid", 64'(ex_valid), 1);
        check("addi_stall_cnt", 64'(stall_cnt), 1);

        // rt used by sw: stall.
        drive_lw(5'd10);
        tick();
        drive_nop();
        id_mem_w = 1; id_alu_src = 1; id_rs = 5'd5; id_rt = 5'd10;
        #1;
        check("sw_pc_write", 64'(pc_write), 0);
        tick();
        check("sw_bubble_valid", 64'(ex_valid), 0);
        check("sw_stall_cnt", 64'(stall_cnt), 2);
        tick();
        check("sw_valid", 64'(ex_valid), 1);
        check("sw_ex_mem_w", 64'(ex_mem_w), 1);

        // Load to $0 never stalls.
        drive_lw(5'd0);
        tick();
        drive_add(5'd0);
        #1;
        check("zero_pc_write", 64'(pc_write), 1);
        tick();
        check("zero_valid", 64'(ex_valid), 1);
        check("zero_stall_cnt", 64'(stall_cnt), 2);

        // Flush outranks the hazard.
        drive_lw(5'd9);
        tick();
        drive_add(5'd9);
        flush = 1;
        #1;
        check("flush_pc_write", 64'(pc_write), 1);
        check("flush_if_id_write", 64'(if_id_write), 1);
        tick();
        check("flush_valid", 64'(ex_valid), 0);
        check("flush_reg_w", 64'(ex_reg_w), 0);
        check("flush_stall_cnt", 64'(stall_cnt), 2);
        flush = 0;

        // Saturation: 19 more load-use pairs from a count of 2.
        for (int i = 1; i <= 19; i++) begin
            drive_lw(5'd9);
            tick();
            drive_add(5'd9);
            tick();
            if (i == 12) check("sat_cnt_14", 64'(stall_cnt), 14);
            if (i == 13) check("sat_cnt_15", 64'(stall_cnt), 15);
        end
        check("sat_cnt_final", 64'(stall_cnt), 15);

        // Asynchronous reset mid-stall.
        drive_lw(5'd9);
        tick();
        drive_add(5'd9);
        #1;
        check("arst_pre_pc_write", 64'(pc_write), 0);
        #1;
        rst_n = 0;
        #1;
        check("arst_valid", 64'(ex_valid), 0);
        check("arst_mem_r", 64'(ex_mem_r), 0);
        check("arst_ex_rt", 64'(ex_rt), 0);
        check("arst_stall_cnt", 64'(stall_cnt), 0);
        check("arst_pc_write", 64'(pc_write), 1);
        tick();
        rst_n = 1;
        check("arst_rel_valid", 64'(ex_valid), 0);
        tick();
        check("arst_first_valid", 64'(ex_valid), 1);
        check("arst_first_reg_w", 64'(ex_reg_w), 1);
        check("arst_first_cnt", 64'(stall_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
